// File: rtl/mul_ucode_ctrl_if.sv
// Decode, register-file read and write-back signals of the multiply microcode controller.
// master = pipeline/register-file side, slave = controller.
interface mul_ucode_ctrl_if #(parameter int DATA_W = 32);
  logic              mul_trigger;
  logic [1:0]        mul_type;
  logic [3:0]        dest_reg;
  logic [3:0]        src1_reg;
  logic [3:0]        src2_reg;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [3:0]        rd_addr1;
  logic [3:0]        rd_addr2;
  logic              stall;
  logic              busy;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ovf;

  modport master (
    output mul_trigger, mul_type, dest_reg, src1_reg, src2_reg, imm, rs1_data, rs2_data,
    input  rd_addr1, rd_addr2, stall, busy, wr_en, wr_addr, wr_data, ovf
  );

  modport slave (
    input  mul_trigger, mul_type, dest_reg, src1_reg, src2_reg, imm, rs1_data, rs2_data,
    output rd_addr1, rd_addr2, stall, busy, wr_en, wr_addr, wr_data, ovf
  );
endinterface

// File: rtl/mul_ucode_ctrl.sv
// Multi-cycle multiply sequencer: latches a decoded mul instruction, reads operands,
// runs a DATA_W-step radix-2 shift-add on magnitudes, fixes the sign and writes back.
module mul_ucode_ctrl #(
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  mul_ucode_ctrl_if.slave bus
);
  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_FIX   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [1:0]          type_r;
  logic [3:0]          dest_r;
  logic [3:0]          src1_r;
  logic [3:0]          src2_r;
  logic [15:0]         imm_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*DATA_W-1:0] acc_r;
  logic [DATA_W-1:0]   mcand_r;
  logic                sign_r;
  logic                ovf_r;
  logic                wr_en_r;
  logic                busy_r;
  logic [DATA_W-1:0]   op_b_s;
  logic [DATA_W:0]     sum_s;
  logic [2*DATA_W-1:0] prod_s;
  logic                ovf_s;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic is_signed);
    if (is_signed && v[DATA_W-1]) begin
      return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // State register and registered status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      wr_en_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      wr_en_r <= (state_next_s == S_WRITE);
      busy_r  <= (state_next_s != S_IDLE);
    end
  end

  // Next-state decode, stall and register-file read addresses.
  always_comb begin
    state_next_s = state_r;
    bus.stall    = 1'b0;
    bus.rd_addr1 = 4'd0;
    bus.rd_addr2 = 4'd0;
    case (state_r)
      S_IDLE: begin
        if (bus.mul_trigger) begin
          state_next_s = S_READ;
          bus.stall    = 1'b1;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_READ: begin
        state_next_s = S_EXEC;
        bus.stall    = 1'b1;
        bus.rd_addr1 = src1_r;
        bus.rd_addr2 = src2_r;
      end
      S_EXEC: begin
        bus.stall = 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_next_s = S_FIX;
        end else begin
          state_next_s = S_EXEC;
        end
      end
      S_FIX: begin
        bus.stall    = 1'b1;
        state_next_s = S_WRITE;
      end
      S_WRITE: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Operand select, one shift-add step, sign fix-up and overflow detection.
  always_comb begin
    if (type_r[0]) begin
      op_b_s = bus.rs2_data;
    end else if (type_r[1]) begin
      op_b_s = {{(DATA_W-16){imm_r[15]}}, imm_r};
    end else begin
      op_b_s = {{(DATA_W-16){1'b0}}, imm_r};
    end
    // The low half of acc holds the not-yet-consumed multiplier bits.
    sum_s  = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + {1'b0, (acc_r[0] ? mcand_r : {DATA_W{1'b0}})};
    prod_s = sign_r ? (~acc_r + {{(2*DATA_W-1){1'b0}}, 1'b1}) : acc_r;
    if (type_r[1]) begin
      ovf_s = (prod_s[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod_s[DATA_W-1]}});
    end else begin
      ovf_s = |prod_s[2*DATA_W-1:DATA_W];
    end
  end

  // Instruction latch, operand capture and multiply datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_r  <= 2'd0;
      dest_r  <= 4'd0;
      src1_r  <= 4'd0;
      src2_r  <= 4'd0;
      imm_r   <= 16'd0;
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {(2*DATA_W){1'b0}};
      mcand_r <= {DATA_W{1'b0}};
      sign_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.mul_trigger) begin
            type_r <= bus.mul_type;
            dest_r <= bus.dest_reg;
            src1_r <= bus.src1_reg;
            src2_r <= bus.src2_reg;
            imm_r  <= bus.imm;
          end
        end
        S_READ: begin
          mcand_r <= magnitude(bus.rs1_data, type_r[1]);
          acc_r   <= {{DATA_W{1'b0}}, magnitude(op_b_s, type_r[1])};
          sign_r  <= type_r[1] & (bus.rs1_data[DATA_W-1] ^ op_b_s[DATA_W-1]);
          cnt_r   <= {CNT_W{1'b0}};
        end
        S_EXEC: begin
          acc_r <= {sum_s, acc_r[DATA_W-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
        end
        S_FIX: begin
          acc_r <= prod_s;
          ovf_r <= ovf_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.wr_en   = wr_en_r;
  assign bus.busy    = busy_r;
  assign bus.wr_addr = dest_r;
  assign bus.wr_data = acc_r[DATA_W-1:0];
  assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_mul_ucode_ctrl.sv
// Scoreboard bench for mul_ucode_ctrl: expectations come from a 64-bit arithmetic model
// pushed at trigger time and popped when the write strobe appears.
module tb_mul_ucode_ctrl;
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rf [16];
  exp_t        exp_q [$];

  mul_ucode_ctrl_if #(.DATA_W(32)) bus ();

  mul_ucode_ctrl #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.rs1_data = rf[bus.rd_addr1];
  assign bus.rs2_data = rf[bus.rd_addr2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [1:0] t, input logic [3:0] d, input logic [31:0] a,
                                 input logic [31:0] b_reg, input logic [15:0] im, input int c);
    exp_t               e;
    logic        [31:0] b;
    logic signed [63:0] ps;
    logic        [63:0] pu;
    b = t[0] ? b_reg : (t[1] ? {{16{im[15]}}, im} : {16'h0000, im});
    e.addr = d;
    e.cyc  = c;
    if (t[1]) begin
      ps     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      e.data = ps[31:0];
      e.ovf  = (ps > 64'sd2147483647) || (ps < -64'sd2147483648);
    end else begin
      pu     = {32'h0, a} * {32'h0, b};
      e.data = pu[31:0];
      e.ovf  = |pu[63:32];
    end
    return e;
  endfunction

  task automatic drive_op(input logic [1:0] t, input logic [3:0] d, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [15:0] im, output logic stall_t);
    bus.mul_trigger = 1'b1;
    bus.mul_type    = t;
    bus.dest_reg    = d;
    bus.src1_reg    = s1;
    bus.src2_reg    = s2;
    bus.imm         = im;
    #1 stall_t = bus.stall;
    exp_q.push_back(model(t, d, rf[s1], rf[s2], im, cyc + 35));
    @(posedge clk); #1;
    bus.mul_trigger = 1'b0;
  endtask

  task automatic wait_write(output logic seen, output int wcyc, output logic [31:0] d,
                            output logic [3:0] a, output logic o);
    seen = 1'b0; wcyc = 0; d = 32'h0; a = 4'h0; o = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        seen = 1'b1; wcyc = cyc; d = bus.wr_data; a = bus.wr_addr; o = bus.ovf;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.mul_trigger = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mul_trigger = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    n_checks++; if (bus.wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", bus.wr_data); end
    n_checks++; if (bus.wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 0", bus.wr_addr); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.rd_addr1 !== 4'h0 || bus.rd_addr2 !== 4'h0) begin
      n_fail++; $display("FAIL reset_rd_addr: got %h/%h expected 0/0", bus.rd_addr1, bus.rd_addr2);
    end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_trigger_ignored: busy %b expected 0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic st;
    logic exp_b;
    exp_t e;
    rf[1] = 32'd7;
    drive_op(2'd0, 4'd2, 4'd1, 4'd0, 16'h0006, st);
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL basic_stall_T: got %b expected 1", st); end
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      exp_b = (k <= 34);
      n_checks++; if (bus.stall !== exp_b) begin n_fail++; $display("FAIL basic_stall T+%0d: got %b expected %b", k, bus.stall, exp_b); end
      exp_b = (k == 35);
      n_checks++; if (bus.wr_en !== exp_b) begin n_fail++; $display("FAIL basic_wr_en T+%0d: got %b expected %b", k, bus.wr_en, exp_b); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy T+%0d: got %b expected 1", k, bus.busy); end
      n_checks++; if (bus.rd_addr1 !== ((k == 1) ? 4'd1 : 4'd0)) begin
        n_fail++; $display("FAIL basic_rd_addr1 T+%0d: got %h", k, bus.rd_addr1);
      end
    end
    e = exp_q.pop_front();
    n_checks++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL basic_latency: got cycle %0d expected %0d", cyc, e.cyc); end
    n_checks++; if (bus.wr_data !== e.data) begin n_fail++; $display("FAIL basic_data: got %h expected %h", bus.wr_data, e.data); end
    n_checks++; if (bus.wr_addr !== e.addr) begin n_fail++; $display("FAIL basic_addr: got %h expected %h", bus.wr_addr, e.addr); end
    n_checks++; if (bus.ovf !== e.ovf) begin n_fail++; $display("FAIL basic_ovf: got %b expected %b", bus.ovf, e.ovf); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_write: busy %b wr_en %b expected 0 0", bus.busy, bus.wr_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    logic [1:0]  ty [4] = '{2'd2, 2'd1, 2'd3, 2'd3};
    logic [31:0] va [4] = '{32'hFFFFFFFD, 32'h00010000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] vb [4] = '{32'h0, 32'h00010000, 32'hFFFFFFFF, 32'h00000005};
    logic [15:0] vi [4] = '{16'hFFFE, 16'h0, 16'h0, 16'h0};
    logic        st, seen, o;
    int          wc;
    logic [31:0] d;
    logic [3:0]  a;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      rf[8] = va[i];
      rf[9] = vb[i];
      drive_op(ty[i], 4'(i + 10), 4'd8, 4'd9, vi[i], st);
      wait_write(seen, wc, d, a, o);
      e = exp_q.pop_front();
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL signed%0d_timeout: no wr_en seen", i); end
      n_checks++; if (wc !== e.cyc) begin n_fail++; $display("FAIL signed%0d_latency: got %0d expected %0d", i, wc, e.cyc); end
      n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL signed%0d_data: got %h expected %h", i, d, e.data); end
      n_checks++; if (a !== e.addr) begin n_fail++; $display("FAIL signed%0d_addr: got %h expected %h", i, a, e.addr); end
      n_checks++; if (o !== e.ovf) begin n_fail++; $display("FAIL signed%0d_ovf: got %b expected %b", i, o, e.ovf); end
      @(negedge clk);
      n_checks++; if (bus.ovf !== e.ovf) begin n_fail++; $display("FAIL signed%0d_ovf_hold: got %b expected %b", i, bus.ovf, e.ovf); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore;
    logic        st, seen, o;
    int          wc;
    logic [31:0] d;
    logic [3:0]  a;
    exp_t        e;
    rf[4] = 32'd9;
    rf[5] = 32'd11;
    drive_op(2'd1, 4'd5, 4'd4, 4'd5, 16'h0, st);
    bus.mul_trigger = 1'b1;
    bus.mul_type    = 2'd0;
    bus.dest_reg    = 4'd7;
    bus.src1_reg    = 4'd5;
    bus.imm         = 16'h0003;
    wait_write(seen, wc, d, a, o);
    bus.mul_trigger = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (wc !== e.cyc) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", wc, e.cyc); end
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL ignore_data: got %h expected %h", d, e.data); end
    n_checks++; if (a !== e.addr) begin n_fail++; $display("FAIL ignore_addr: got %h expected %h", a, e.addr); end
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: busy %b expected 0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    logic        st, seen, o, any_wr;
    int          wc;
    logic [31:0] d;
    logic [3:0]  a;
    exp_t        e;
    rf[2] = 32'd100;
    rf[3] = 32'd200;
    drive_op(2'd1, 4'd9, 4'd2, 4'd3, 16'h0, st);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall: got %b expected 0", bus.stall); end
    any_wr = bus.wr_en;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.wr_en !== 1'b0) any_wr = 1'b1;
    end
    n_checks++; if (any_wr !== 1'b0) begin n_fail++; $display("FAIL abort_no_write: got wr_en %b expected 0", any_wr); end
    @(posedge clk); #1;
    rf[1] = 32'd3;
    drive_op(2'd0, 4'd6, 4'd1, 4'd0, 16'h0004, st);
    wait_write(seen, wc, d, a, o);
    e = exp_q.pop_front();
    n_checks++; if (wc !== e.cyc) begin n_fail++; $display("FAIL abort_new_latency: got %0d expected %0d", wc, e.cyc); end
    n_checks++; if (d !== 32'd12) begin n_fail++; $display("FAIL abort_new_data: got %h expected 0000000c", d); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic        st, seen, o;
    int          wc, first_wc;
    logic [31:0] d;
    logic [3:0]  a;
    exp_t        e;
    rf[3] = 32'd5;
    rf[4] = 32'd5;
    drive_op(2'd1, 4'd3, 4'd3, 4'd4, 16'h0, st);
    wait_write(seen, wc, d, a, o);
    e = exp_q.pop_front();
    first_wc = wc;
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL b2b_first_data: got %h expected %h", d, e.data); end
    n_checks++; if (a !== 4'd3) begin n_fail++; $display("FAIL b2b_first_addr: got %h expected 3", a); end
    @(posedge clk); #1;
    rf[5] = 32'hFFFFFFF9;
    rf[6] = 32'd6;
    drive_op(2'd3, 4'd0, 4'd5, 4'd6, 16'h0, st);
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_stall: got %b expected 1", st); end
    wait_write(seen, wc, d, a, o);
    e = exp_q.pop_front();
    n_checks++; if (wc !== first_wc + 36) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", wc, first_wc + 36); end
    n_checks++; if (d !== e.data) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", d, e.data); end
    n_checks++; if (a !== e.addr || seen !== 1'b1) begin n_fail++; $display("FAIL b2b_addr0: got %h seen %b expected %h", a, seen, e.addr); end
    n_checks++; if (o !== e.ovf) begin n_fail++; $display("FAIL b2b_ovf: got %b expected %b", o, e.ovf); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.mul_trigger = 1'b0;
    bus.mul_type    = 2'd0;
    bus.dest_reg    = 4'd0;
    bus.src1_reg    = 4'd0;
    bus.src2_reg    = 4'd0;
    bus.imm         = 16'h0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    test_reset();
    test_basic();
    test_signed();
    test_ignore();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
